// File: rtl/counter_run_ctrl.sv
// Run controller for a 0..limit counter that repeats for a number of passes.
// Supports pause (HOLD), abort (stop) and a DONE state that waits for the next start.
module counter_run_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic       pause,
   input  logic [9:0] limit,
   input  logic [7:0] passes,
   output logic [9:0] count,
   output logic       wrap,
   output logic [7:0] pass_cnt,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

   state_t     state_reg, state_next;
   logic [9:0] lim_reg, lim_next;
   logic [7:0] passes_reg, passes_next;
   logic [9:0] count_next;
   logic [7:0] pass_next;
   logic       wrap_next, busy_next, done_next;
   logic [9:0] limit_clamped;
   logic [7:0] pass_inc;
   logic       at_lim, last_pass;

   assign limit_clamped = (limit > 10'd999) ? 10'd999 : limit;
   assign pass_inc      = pass_cnt + 8'd1;
   assign at_lim        = (count == lim_reg);
   // A HOLD entered at the terminal count can never be terminal, so this is safe in HOLD too
   assign last_pass     = at_lim && (passes_reg != 8'd0) && (pass_inc == passes_reg);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= IDLE;
         lim_reg    <= 10'd0;
         passes_reg <= 8'd0;
         count      <= 10'd0;
         pass_cnt   <= 8'd0;
         wrap       <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state_reg  <= state_next;
         lim_reg    <= lim_next;
         passes_reg <= passes_next;
         count      <= count_next;
         pass_cnt   <= pass_next;
         wrap       <= wrap_next;
         busy       <= busy_next;
         done       <= done_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      lim_next    = lim_reg;
      passes_next = passes_reg;
      count_next  = count;
      pass_next   = pass_cnt;
      wrap_next   = 1'b0;
      busy_next   = busy;
      done_next   = done;
      case (state_reg)
         IDLE, DONE: begin
            if (start) begin
               state_next  = RUN;
               lim_next    = limit_clamped;
               passes_next = passes;
               count_next  = 10'd0;
               pass_next   = 8'd0;
               busy_next   = 1'b1;
               done_next   = 1'b0;
            end
         end
         RUN, HOLD: begin
            if (stop) begin
               state_next = IDLE;
               count_next = 10'd0;
               busy_next  = 1'b0;
               done_next  = 1'b0;
            end else if (last_pass) begin
               state_next = DONE;
               count_next = 10'd0;
               pass_next  = pass_inc;
               wrap_next  = 1'b1;
               busy_next  = 1'b0;
               done_next  = 1'b1;
            end else if (pause) begin
               state_next = HOLD;
            end else begin
               // Leaving HOLD counts on the same edge
               state_next = RUN;
               if (at_lim) begin
                  count_next = 10'd0;
                  pass_next  = pass_inc;
                  wrap_next  = 1'b1;
               end else begin
                  count_next = count + 10'd1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule
